adder_arb: RTL

Round-robin arbiter and sequencer that shares one registered 26-bit add/subtract core (A, B, C_IN, ADD → Q) among N requesters. It accepts one operation per cycle from the highest-priority requesting client, drives the core's operand ports from a register stage, and tracks each issued operation through a tag pipeline matched to the core latency. It routes each result back to its originator with a one-cycle valid strobe. It sits between the per-channel datapath blocks and the single shared adder core instance.

---
 rtl/adder_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/adder_arb.sv
// adder_arb: round-robin arbiter/sequencer in front of one shared, registered
// add/subtract core. One operation per cycle is granted from the requester
// that follows the last grantee in rotation. The winner's operands go into the
// core input registers. A {valid,id} tag rides a LAT-deep pipeline beside the
// core, so each result is steered back to its originator.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req[N]              per-requester request, operands held until ack
//   req_a/req_b[N*W]    operands, requester i at [i*W +: W]
//   req_cin[N]          carry/borrow in
//   req_add[N]          1 = add, 0 = subtract
//   ack[N]              registered one-hot grant acknowledge
//   core_a/core_b       registered core operand ports
//   core_c_in/core_add  registered core control ports
//   core_q              core result, LAT cycles after the core inputs
//   res_q               result data (core_q pass-through)
//   res_valid[N]        registered one-hot owner of res_q this cycle
//   idle                no ack pending and no tag in flight
module adder_arb #(
  parameter int N   = 4,
  parameter int W   = 26,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_cin,
  input  logic [N-1:0]   req_add,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   core_a,
  output logic [W-1:0]   core_b,
  output logic           core_c_in,
  output logic           core_add,
  input  logic [W-1:0]   core_q,
  output logic [W-1:0]   res_q,
  output logic [N-1:0]   res_valid,
  output logic           idle
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [N-1:0]         ack_q, ack_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [W-1:0]         core_a_q, core_a_d, core_b_q, core_b_d;
  logic                 core_c_in_q, core_c_in_d, core_add_q, core_add_d;
  tag_t [LAT-1:0]       tag_q, tag_d;
  logic [N-1:0]         res_valid_q, res_valid_d;

  logic [N-1:0]         elig;
  logic                 gnt_vld;
  logic [IDW-1:0]       gnt_id;
  logic                 tag_busy;

  // Rotating search: start just after the last grantee so every requester
  // is reached within N-1 cycles. A requester whose ack is up is masked so a
  // held request is not issued twice.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = req & ~ack_q;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    ack_d       = '0;
    last_d      = last_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_c_in_d = core_c_in_q;
    core_add_d  = core_add_q;
    if (gnt_vld) begin
      ack_d[gnt_id] = 1'b1;
      last_d        = gnt_id;
      core_a_d      = req_a[gnt_id*W +: W];
      core_b_d      = req_b[gnt_id*W +: W];
      core_c_in_d   = req_cin[gnt_id];
      core_add_d    = req_add[gnt_id];
    end
  end

  // Tag pipeline tracks the core: stage 0 is loaded alongside the core input
  // registers, and the last stage is decoded into the registered res_valid so
  // it lines up with core_q.
  always_comb begin
    tag_d[0].vld = gnt_vld;
    tag_d[0].id  = gnt_id;
    for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
    res_valid_d = '0;
    if (tag_q[LAT-1].vld) res_valid_d[tag_q[LAT-1].id] = 1'b1;
    tag_busy = 1'b0;
    for (int s = 0; s < LAT; s++) tag_busy = tag_busy | tag_q[s].vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= '0;
      last_q      <= IDW'(N - 1);
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_c_in_q <= 1'b0;
      core_add_q  <= 1'b1;
      tag_q       <= '0;
      res_valid_q <= '0;
    end else begin
      ack_q       <= ack_d;
      last_q      <= last_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_c_in_q <= core_c_in_d;
      core_add_q  <= core_add_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign ack       = ack_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign core_c_in = core_c_in_q;
  assign core_add  = core_add_q;
  assign res_q     = core_q;
  assign res_valid = res_valid_q;
  assign idle      = ~|ack_q & ~tag_busy;

endmodule
